regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//   Shares the single register-file write port (RegWrite/WriteReg/WriteData)
//   among NUM_REQ writeback sources, e.g. ALU, load unit and multi-cycle unit.
//   Round-robin arbitration with a valid/ready handshake per source.
//   The write-port outputs are registered and feed the register file directly.
// PARAMETERS
//   NUM_REQ  3   number of requesters, 2..8
//   IDW      2   width of GrantId; must satisfy 2**IDW >= NUM_REQ
// PORTS
//   Clock      in   1            rising-edge clock
//   Clear_n    in   1            asynchronous reset, active low
//   Hold       in   1            pipeline stall; 1 = grant nothing this cycle
//   ReqValid   in   NUM_REQ      source i has a write pending
//   ReqReg     in   5*NUM_REQ    destination register, source i in bits [5i+4:5i]
//   ReqData    in   32*NUM_REQ   write data, source i in bits [32i+31:32i]
//   ReqReady   out  NUM_REQ      combinational grant; transfer = Valid & Ready
//   RegWrite   out  1            registered write enable to the register file
//   WriteReg   out  5            registered destination register number
//   WriteData  out  32           registered write data
//   GrantId    out  IDW          index of the source that produced the current RegWrite
// BEHAVIOUR
//   - Reset (Clear_n=0, asynchronous): Ptr=0, RegWrite=0, WriteReg=0,
//     WriteData=0, GrantId=0. ReqReady=0 while Clear_n=0.
//   - Ptr is the highest-priority index. Each cycle, the first i with
//     ReqValid[i]=1, scanning Ptr, Ptr+1, ... (mod NUM_REQ), wins.
//   - At most one ReqReady bit is high per cycle, only for the winner.
//     ReqReady is combinational from ReqValid, Ptr and Hold (no registered path).
//   - At the edge after a transfer: RegWrite<=1, WriteReg<=winner's ReqReg,
//     WriteData<=winner's ReqData, GrantId<=winner, Ptr<=winner+1.
//     Wrap: winner NUM_REQ-1 sets Ptr to 0.
//   - Latency: exactly 1 cycle from accept to RegWrite. A new write can be
//     accepted every cycle (full throughput).
//   - No transfer in a cycle (no valid source, or Hold=1): RegWrite<=0;
//     WriteReg, WriteData, GrantId and Ptr hold their values.
//   - Hold=1 forces ReqReady=0. A write already in the output register still
//     completes on the following cycle.
//   - Sources hold ReqValid, ReqReg and ReqData stable until they see ReqReady.
//     Deasserting ReqValid before the grant is allowed and drops the request.
//   - Reset mid-operation: an accepted write not yet presented on RegWrite is
//     discarded. Sources treat reset as flushing all writebacks.
//   - Unused GrantId codes (>= NUM_REQ) are never produced.
// CONFIGURATION
//   ZERO_DROP_EN defined:
//     - A source with ReqValid=1 and ReqReg=0 gets ReqReady=1 in the same
//       cycle, independent of Ptr, and even when Hold=1.
//     - That transfer does not take the write-port slot: no RegWrite and no
//       Ptr change.
//     - Several r0 requests are all acked in the same cycle. Sources targeting
//       r0 are excluded from the round-robin scan.
//   ZERO_DROP_EN undefined:
//     - r0 requests arbitrate like any other and produce RegWrite=1 with
//       WriteReg=0. The register file ignores that write.
// TESTING
//   1. Reset: Clear_n=0 during traffic -> all outputs 0 at once; after release,
//      Ptr=0 and the first grant goes to the lowest valid index.
//   2. Single source: ReqValid=3'b010, ReqReg[9:5]=5, data 0xDEADBEEF ->
//      ReqReady=3'b010 the same cycle; next cycle RegWrite=1, WriteReg=5,
//      WriteData=0xDEADBEEF, GrantId=1.
//   3. Round-robin: ReqValid=3'b111 held for 6 cycles -> grants 0,1,2,0,1,2 and
//      RegWrite=1 every cycle. Wrap 2->0 is checked.
//   4. Hold: ReqValid=3'b001, Hold=1 for 3 cycles -> ReqReady=0 and RegWrite=0
//      (after any in-flight write drains); the grant occurs in the cycle Hold
//      drops.
//   5. Fairness: source 0 always valid, source 2 becomes valid -> source 2 is
//      granted within NUM_REQ cycles.
//   6. r0 write, ReqValid=3'b011 with ReqReg0=0, ReqReg1=7:
//      ZERO_DROP_EN -> both ready in the same cycle; one RegWrite with WriteReg=7.
//      Undefined -> two serial RegWrites, WriteReg 0 then 7.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port among NUM_REQ writeback
// sources (ALU, load unit, multi-cycle unit, ...). Round-robin arbitration
// with a valid/ready handshake per source. A transfer is ReqValid & ReqReady.
// Accepted writes appear one cycle later on registered write-port outputs.
//
// Parameters:
//   NUM_REQ  number of requesters, 2..8
//   IDW      width of GrantId, 2**IDW >= NUM_REQ
//
// Ports:
//   Clock      in   rising-edge clock
//   Clear_n    in   asynchronous reset, active low
//   Hold       in   pipeline stall, grants nothing while high
//   ReqValid   in   [NUM_REQ]     per-source write pending
//   ReqReg     in   [5*NUM_REQ]   per-source destination register
//   ReqData    in   [32*NUM_REQ]  per-source write data
//   ReqReady   out  [NUM_REQ]     combinational grant
//   RegWrite   out  registered write enable
//   WriteReg   out  registered destination register
//   WriteData  out  registered write data
//   GrantId    out  index of the source behind the current RegWrite
//
// Optional feature (macro ZERO_DROP_EN):
//   When defined, requests to r0 are acknowledged at once (even while Hold
//   is high) and silently dropped. They never use the write-port slot and
//   take no part in the round-robin scan. When undefined, r0 writes
//   arbitrate normally and reach the register file, which ignores them.
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDW     = 2
) (
    input  logic                  Clock,
    input  logic                  Clear_n,
    input  logic                  Hold,
    input  logic [NUM_REQ-1:0]    ReqValid,
    input  logic [5*NUM_REQ-1:0]  ReqReg,
    input  logic [32*NUM_REQ-1:0] ReqData,
    output logic [NUM_REQ-1:0]    ReqReady,
    output logic                  RegWrite,
    output logic [4:0]            WriteReg,
    output logic [31:0]           WriteData,
    output logic [IDW-1:0]        GrantId
);

    // Index base+off reduced modulo NUM_REQ; both arguments are below NUM_REQ
    // so a single conditional subtract is enough.
    function automatic logic [IDW-1:0] wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return sum[IDW-1:0];
    endfunction

    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     ptr_d;
    logic               regwrite_q;
    logic               regwrite_d;
    logic [4:0]         writereg_q;
    logic [4:0]         writereg_d;
    logic [31:0]        writedata_q;
    logic [31:0]        writedata_d;
    logic [IDW-1:0]     grant_id_q;
    logic [IDW-1:0]     grant_id_d;

    logic [NUM_REQ-1:0] zero_s;
    logic [NUM_REQ-1:0] elig_s;
    logic               grant_found_s;
    logic [IDW-1:0]     grant_idx_s;
    logic               xfer_s;
    logic [NUM_REQ-1:0] ready_s;

    // Sources whose request is absorbed without touching the write port.
    always_comb begin
        zero_s = '0;
`ifdef ZERO_DROP_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            zero_s[i] = ReqValid[i] && (ReqReg[5*i +: 5] == 5'd0);
        end
`endif
        elig_s = ReqValid & ~zero_s;
    end

    // Round-robin scan starting at ptr_q; first eligible source wins.
    always_comb begin : rr_scan
        logic [IDW-1:0] cand;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_idx(int'(ptr_q), k);
            if (!grant_found_s && elig_s[cand]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Combinational ready: round-robin winner unless stalled, plus any
    // absorbed r0 requests; nothing is acknowledged while in reset.
    always_comb begin
        ready_s = '0;
        xfer_s  = grant_found_s && !Hold;
        if (xfer_s) begin
            ready_s[grant_idx_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
        if (Clear_n) begin
            ready_s = ready_s | zero_s;
        end else begin
            ready_s = '0;
        end
    end

    assign ReqReady = ready_s;

    // Next state of the write-port register and the priority pointer.
    always_comb begin
        regwrite_d  = xfer_s;
        writereg_d  = writereg_q;
        writedata_d = writedata_q;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        if (xfer_s) begin
            writereg_d  = ReqReg[int'(grant_idx_s)*5 +: 5];
            writedata_d = ReqData[int'(grant_idx_s)*32 +: 32];
            grant_id_d  = grant_idx_s;
            ptr_d       = wrap_idx(int'(grant_idx_s), 1);
        end else begin
            ptr_d       = ptr_q;
        end
    end

    // Write-port output register and round-robin pointer.
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            ptr_q       <= '0;
            regwrite_q  <= 1'b0;
            writereg_q  <= 5'd0;
            writedata_q <= 32'd0;
            grant_id_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
            grant_id_q  <= grant_id_d;
        end
    end

    assign RegWrite  = regwrite_q;
    assign WriteReg  = writereg_q;
    assign WriteData = writedata_q;
    assign GrantId   = grant_id_q;

endmodule
